// File: rtl/tc_stack_param_if.sv
// Bus bundle for the parameterised LIFO: request/data inputs plus registered pop data and status.
interface tc_stack_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             clr;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic [WIDTH-1:0] peek;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output clr, push, pop, in,
        input  out, out_valid, peek, count, empty, full, overflow, underflow
    );

    modport slave (
        input  clr, push, pop, in,
        output out, out_valid, peek, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/tc_stack_param.sv
// Parametrised LIFO stack with push, pop, exchange and empty-bypass on a single edge,
// sticky overflow/underflow flags and a synchronous clear.
module tc_stack_param #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    tc_stack_param_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp;
    logic [WIDTH-1:0] out_q;
    logic             out_valid_q;
    logic             overflow_q;
    logic             underflow_q;

    logic             empty;
    logic             full;
    logic             wr_en;
    logic [AW-1:0]    top_addr;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] top_data;

    assign empty    = (sp == '0);
    assign full     = (sp == CW'(DEPTH));
    assign top_addr = AW'(sp - CW'(1));
    assign top_data = mem[top_addr];

    // Exchange overwrites the current top; a plain push writes the next free slot.
    // Gating with rst_n keeps a write coinciding with reset from landing.
    assign wr_en   = rst_n && !bus.clr && bus.push && (bus.pop ? !empty : !full);
    assign wr_addr = bus.pop ? top_addr : AW'(sp);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp          <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.clr) begin
            sp          <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case ({bus.push, bus.pop})
                2'b10: begin
                    if (!full) begin
                        sp <= sp + CW'(1);
                    end else begin
                        overflow_q <= 1'b1;
                    end
                end
                2'b01: begin
                    if (!empty) begin
                        out_q       <= top_data;
                        sp          <= sp - CW'(1);
                        out_valid_q <= 1'b1;
                    end else begin
                        underflow_q <= 1'b1;
                    end
                end
                2'b11: begin
                    // Empty stack: the pushed word passes straight through to out.
                    out_q       <= empty ? bus.in : top_data;
                    out_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.peek      = empty ? '0 : top_data;
    assign bus.count     = sp;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_tc_stack_param.sv
// Bench for tc_stack_param: directed steps on a 256-deep and a 4-deep stack, then random
// traffic on a 13-bit x 5-deep stack against a queue-based reference model.
module tb_tc_stack_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    tc_stack_param_if #(.WIDTH(8),  .DEPTH(256)) b0 ();
    tc_stack_param_if #(.WIDTH(8),  .DEPTH(4))   b1 ();
    tc_stack_param_if #(.WIDTH(13), .DEPTH(5))   b2 ();

    tc_stack_param #(.WIDTH(8),  .DEPTH(256)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    tc_stack_param #(.WIDTH(8),  .DEPTH(4))   u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    tc_stack_param #(.WIDTH(13), .DEPTH(5))   u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    // Reference model for u2: stack contents as a queue, top at the back.
    logic [12:0] mq[$];
    logic [12:0] m_out = '0;
    logic        m_ov = 1'b0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic c, input logic p, input logic o, input logic [12:0] d);
        m_ov = 1'b0;
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (p && !o) begin
            if (mq.size() < 5) mq.push_back(d);
            else m_ovf = 1'b1;
        end else if (!p && o) begin
            if (mq.size() > 0) begin
                m_out = mq.pop_back();
                m_ov  = 1'b1;
            end else begin
                m_unf = 1'b1;
            end
        end else if (p && o) begin
            if (mq.size() > 0) begin
                m_out = mq[mq.size()-1];
                mq[mq.size()-1] = d;
            end else begin
                m_out = d;
            end
            m_ov = 1'b1;
        end
    endtask

    task automatic check_model(input int n);
        logic [12:0] pk;
        pk = (mq.size() > 0) ? mq[mq.size()-1] : 13'h0;
        check($sformatf("rnd%0d_count", n), 32'(b2.count), 32'(mq.size()));
        check($sformatf("rnd%0d_peek", n), 32'(b2.peek), 32'(pk));
        check($sformatf("rnd%0d_out", n), 32'(b2.out), 32'(m_out));
        check($sformatf("rnd%0d_ov", n), 32'(b2.out_valid), 32'(m_ov));
        check($sformatf("rnd%0d_empty", n), 32'(b2.empty), 32'(mq.size() == 0));
        check($sformatf("rnd%0d_full", n), 32'(b2.full), 32'(mq.size() == 5));
        check($sformatf("rnd%0d_ovf", n), 32'(b2.overflow), 32'(m_ovf));
        check($sformatf("rnd%0d_unf", n), 32'(b2.underflow), 32'(m_unf));
    endtask

    initial begin
        logic c, p, o;
        logic [12:0] d;

        b0.clr = 0; b0.push = 0; b0.pop = 0; b0.in = '0;
        b1.clr = 0; b1.push = 0; b1.pop = 0; b1.in = '0;
        b2.clr = 0; b2.push = 0; b2.pop = 0; b2.in = '0;

        tick();
        tick();
        check("rst_count", 32'(b0.count), 32'd0);
        check("rst_empty", 32'(b0.empty), 32'd1);
        check("rst_out", 32'(b0.out), 32'd0);
        check("rst_ov", 32'(b0.out_valid), 32'd0);
        check("rst_peek", 32'(b0.peek), 32'd0);
        check("rst_flags", {30'd0, b0.overflow, b0.underflow}, 32'd0);
        rst_n = 1'b1;

        // Push three, pop three.
        b0.push = 1; b0.in = 8'h11; tick();
        b0.in = 8'h22; tick();
        b0.in = 8'h33; tick();
        b0.push = 0;
        check("t1_count", 32'(b0.count), 32'd3);
        check("t1_peek", 32'(b0.peek), 32'h33);
        b0.pop = 1; tick();
        check("t1_pop1_out", 32'(b0.out), 32'h33);
        check("t1_pop1_ov", 32'(b0.out_valid), 32'd1);
        tick();
        check("t1_pop2_out", 32'(b0.out), 32'h22);
        check("t1_pop2_ov", 32'(b0.out_valid), 32'd1);
        tick();
        check("t1_pop3_out", 32'(b0.out), 32'h11);
        check("t1_pop3_ov", 32'(b0.out_valid), 32'd1);
        check("t1_empty", 32'(b0.empty), 32'd1);

        // Pop on empty, then clear.
        tick();
        b0.pop = 0;
        check("t3_unf", 32'(b0.underflow), 32'd1);
        check("t3_ov", 32'(b0.out_valid), 32'd0);
        check("t3_out_hold", 32'(b0.out), 32'h11);
        check("t3_count", 32'(b0.count), 32'd0);
        b0.clr = 1; tick();
        b0.clr = 0;
        check("t3_clr_unf", 32'(b0.underflow), 32'd0);
        check("t3_clr_out_hold", 32'(b0.out), 32'h11);

        // Exchange on a two-deep stack.
        b0.push = 1; b0.in = 8'hA0; tick();
        b0.in = 8'hB0; tick();
        b0.pop = 1; b0.in = 8'hC0; tick();
        b0.push = 0; b0.pop = 0;
        check("t4_out", 32'(b0.out), 32'hB0);
        check("t4_ov", 32'(b0.out_valid), 32'd1);
        check("t4_count", 32'(b0.count), 32'd2);
        check("t4_peek", 32'(b0.peek), 32'hC0);
        tick();
        check("t4_ov_drop", 32'(b0.out_valid), 32'd0);

        // Bypass on empty.
        b0.clr = 1; tick();
        b0.clr = 0;
        check("t5_clr_count", 32'(b0.count), 32'd0);
        b0.push = 1; b0.pop = 1; b0.in = 8'h5A; tick();
        b0.push = 0; b0.pop = 0;
        check("t5_out", 32'(b0.out), 32'h5A);
        check("t5_ov", 32'(b0.out_valid), 32'd1);
        check("t5_count", 32'(b0.count), 32'd0);
        check("t5_flags", {30'd0, b0.overflow, b0.underflow}, 32'd0);

        // DEPTH=4: overflow, pop, exchange while full.
        b1.push = 1;
        for (int i = 1; i <= 5; i++) begin
            b1.in = 8'(i);
            tick();
            if (i == 4) check("t2_full4", 32'(b1.full), 32'd1);
        end
        b1.push = 0;
        check("t2_ovf", 32'(b1.overflow), 32'd1);
        check("t2_count", 32'(b1.count), 32'd4);
        check("t2_peek", 32'(b1.peek), 32'd4);
        b1.pop = 1; tick();
        b1.pop = 0;
        check("t2_pop_out", 32'(b1.out), 32'd4);
        check("t2_pop_count", 32'(b1.count), 32'd3);
        b1.push = 1; b1.in = 8'h07; tick();
        b1.pop = 1; b1.in = 8'h09; tick();
        b1.push = 0; b1.pop = 0;
        check("t4_xfull_out", 32'(b1.out), 32'h07);
        check("t4_xfull_count", 32'(b1.count), 32'd4);
        check("t4_xfull_peek", 32'(b1.peek), 32'h09);
        check("t4_xfull_flags", {30'd0, b1.overflow, b1.underflow}, 32'd2);

        // Asynchronous reset between edges.
        b0.push = 1;
        for (int i = 1; i <= 3; i++) begin
            b0.in = 8'(8'h40 + i);
            tick();
        end
        b0.push = 0; b0.pop = 1; tick();
        b0.pop = 0;
        check("t6_pre_ov", 32'(b0.out_valid), 32'd1);
        check("t6_pre_out", 32'(b0.out), 32'h43);
        #2 rst_n = 1'b0;
        #1;
        check("t6_count", 32'(b0.count), 32'd0);
        check("t6_out", 32'(b0.out), 32'd0);
        check("t6_ov", 32'(b0.out_valid), 32'd0);
        check("t6_b1_count", 32'(b1.count), 32'd0);
        check("t6_b1_ovf", 32'(b1.overflow), 32'd0);
        tick();
        rst_n = 1'b1;
        check("t6_b2_reset", 32'(b2.count), 32'd0);

        // Random traffic vs. model; push-heavy first half, pop-heavy second half.
        for (int n = 0; n < 400; n++) begin
            c = ($urandom_range(31) == 0);
            if (n < 200) begin
                p = ($urandom_range(9) < 7);
                o = ($urandom_range(9) < 3);
            end else begin
                p = ($urandom_range(9) < 3);
                o = ($urandom_range(9) < 7);
            end
            d = 13'($urandom);
            b2.clr = c; b2.push = p; b2.pop = o; b2.in = d;
            tick();
            model_step(c, p, o, d);
            check_model(n);
        end
        b2.clr = 0; b2.push = 0; b2.pop = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
